// File: rtl/adc_pkg.sv
// Shared types, frame constants and the MCP3202 command-bit helper for the ADC sample source.
package adc_pkg;

  localparam int unsigned FRAME_BITS = 17;
  localparam int unsigned NULL_BIT   = 4;
  localparam int unsigned DATA_BITS  = 12;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, DONE} state_t;
  typedef enum logic [1:0] {PAIR_IDLE, PAIR_CH0, PAIR_CH1, PAIR_DONE} pair_t;

  // Command nibble {START, SGL, ODD, MSBF} in shift order; bits past the nibble are don't-care.
  function automatic logic cmd_bit(input logic ch, input logic [4:0] idx);
    case (idx)
      5'd0, 5'd1, 5'd3: cmd_bit = 1'b1;
      5'd2:             cmd_bit = ch;
      default:          cmd_bit = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_frame_xfer.sv
// One SPI mode-0 conversion frame (SETUP, 17 SCLK periods, GAP) against an MCP3202-style ADC.
module spi_frame_xfer
  import adc_pkg::*;
#(
  parameter int unsigned CLK_DIV = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 ch_i,
  output logic [DATA_BITS-1:0] word_o,
  output logic                 done_o,
  output logic                 cs_n_o,
  output logic                 sclk_o,
  output logic                 mosi_o,
  input  logic                 miso_i
);

  localparam int unsigned      CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [4:0]       BIT_LAST = 5'(FRAME_BITS - 1);
  localparam logic [4:0]       NULL_IDX = 5'(NULL_BIT);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [4:0]           bit_q, bit_d;
  logic                 ch_q, ch_d;
  logic                 cs_n_q, cs_n_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic [DATA_BITS-1:0] word_q, word_d;
  logic                 last_cnt;
  logic                 launch;

  assign last_cnt = (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      ch_q    <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      ch_q    <= ch_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_i) state_d = SETUP;
      SETUP: if (last_cnt) state_d = SHIFT;
      SHIFT: if (last_cnt && sclk_q && (bit_q == BIT_LAST)) state_d = GAP;
      GAP:   if (last_cnt) state_d = start_i ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A new frame may start straight out of the last GAP cycle, so back-to-back frames need no idle cycle.
  always_comb begin
    launch = start_i && ((state_q == IDLE) || ((state_q == GAP) && last_cnt));
    done_o = (state_q == GAP) && last_cnt;
    cnt_d  = ((state_q == IDLE) || last_cnt) ? '0 : cnt_q + CNT_W'(1);
    bit_d  = bit_q;
    ch_d   = ch_q;
    cs_n_d = cs_n_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    word_d = word_q;
    if (launch) begin
      bit_d  = '0;
      ch_d   = ch_i;
      cs_n_d = 1'b0;
      sclk_d = 1'b0;
      mosi_d = cmd_bit(ch_i, 5'd0);
      word_d = '0;
    end else if ((state_q == SHIFT) && last_cnt) begin
      if (!sclk_q) begin
        sclk_d = 1'b1;
        if (bit_q > NULL_IDX) word_d = {word_q[DATA_BITS-2:0], miso_i};
      end else begin
        sclk_d = 1'b0;
        if (bit_q == BIT_LAST) begin
          cs_n_d = 1'b1;
          mosi_d = 1'b0;
        end else begin
          bit_d  = bit_q + 5'd1;
          mosi_d = cmd_bit(ch_q, bit_q + 5'd1);
        end
      end
    end
  end

  assign word_o = word_q;
  assign cs_n_o = cs_n_q;
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;

endmodule

// File: rtl/adc_sample_source.sv
// Paces a 2-channel SPI ADC: one ch0/ch1 pair per sample period, then a one-cycle update strobe.
// Optional `ADC_SIGNED_OUT_EN presents A/B as two's complement instead of offset binary.
module adc_sample_source
  import adc_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 8,
  parameter int unsigned SAMPLE_PERIOD = 1134
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 adc_cs_n,
  output logic                 adc_sclk,
  output logic                 adc_mosi,
  input  logic                 adc_miso,
  output logic [DATA_BITS-1:0] A,
  output logic [DATA_BITS-1:0] B,
  output logic                 update,
  output logic                 busy,
  output logic                 overrun
);

  localparam int unsigned      TMR_W    = $clog2(SAMPLE_PERIOD);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);

  pair_t                pair_q, pair_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [DATA_BITS-1:0] w0_q, w0_d;
  logic [DATA_BITS-1:0] a_q, a_d;
  logic [DATA_BITS-1:0] b_q, b_d;
  logic                 update_q, update_d;
  logic                 overrun_q, overrun_d;
  logic                 tick;
  logic                 start;
  logic                 ch_sel;
  logic                 xfer_done;
  logic [DATA_BITS-1:0] xfer_word;

  function automatic logic [DATA_BITS-1:0] map_out(input logic [DATA_BITS-1:0] raw);
`ifdef ADC_SIGNED_OUT_EN
    map_out = {~raw[DATA_BITS-1], raw[DATA_BITS-2:0]};
`else
    map_out = raw;
`endif
  endfunction

  spi_frame_xfer #(
    .CLK_DIV (CLK_DIV)
  ) u_xfer (
    .clk_i   (clk),
    .rst_i   (reset),
    .start_i (start),
    .ch_i    (ch_sel),
    .word_o  (xfer_word),
    .done_o  (xfer_done),
    .cs_n_o  (adc_cs_n),
    .sclk_o  (adc_sclk),
    .mosi_o  (adc_mosi),
    .miso_i  (adc_miso)
  );

  assign tick    = enable && (timer_q == TMR_LAST);
  assign timer_d = (!enable || tick) ? '0 : timer_q + TMR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      pair_q    <= PAIR_IDLE;
      timer_q   <= '0;
      w0_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      update_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      pair_q    <= pair_d;
      timer_q   <= timer_d;
      w0_q      <= w0_d;
      a_q       <= a_d;
      b_q       <= b_d;
      update_q  <= update_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    pair_d = pair_q;
    case (pair_q)
      PAIR_IDLE: if (tick) pair_d = PAIR_CH0;
      PAIR_CH0:  if (xfer_done) pair_d = PAIR_CH1;
      PAIR_CH1:  if (xfer_done) pair_d = PAIR_DONE;
      PAIR_DONE: pair_d = PAIR_IDLE;
    endcase
  end

  // ch0 is parked in w0_q so both outputs change together in the DONE cycle.
  always_comb begin
    busy      = (pair_q != PAIR_IDLE);
    start     = ((pair_q == PAIR_IDLE) && tick) || ((pair_q == PAIR_CH0) && xfer_done);
    ch_sel    = (pair_q == PAIR_CH0);
    w0_d      = ((pair_q == PAIR_CH0) && xfer_done) ? xfer_word : w0_q;
    a_d       = a_q;
    b_d       = b_q;
    update_d  = (pair_q == PAIR_DONE);
    overrun_d = overrun_q | (tick && busy);
    if (pair_q == PAIR_DONE) begin
      a_d = map_out(w0_q);
      b_d = map_out(xfer_word);
    end
  end

  assign A       = a_q;
  assign B       = b_q;
  assign update  = update_q;
  assign overrun = overrun_q;

endmodule
